// File: rtl/bit_collector.sv
// Collects masked radix-4 decision groups into packed words and emits the
// per-group partial sums needed by the next decoding stage.
module bit_collector #(
  parameter int WORD_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 u_valid_i,
  input  logic [3:0]           u_i,
  input  logic [3:0]           frozen_i,
  input  logic                 last_i,
  output logic                 u_ready_o,
  output logic [3:0]           ps_o,
  output logic                 ps_valid_o,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_valid_o,
  output logic                 word_last_o,
  input  logic                 word_ready_i
);

  localparam int GROUPS = WORD_BITS / 4;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  function automatic logic [3:0] mask_group(logic [3:0] u, logic [3:0] frozen);
    return u & ~frozen;
  endfunction

  // Bit order is [3]=first position, so x0 = parity of the whole group.
  function automatic logic [3:0] partial_sums(logic [3:0] m);
    logic [3:0] x;
    x[3] = m[3] ^ m[2] ^ m[1] ^ m[0];
    x[2] = m[2] ^ m[0];
    x[1] = m[1] ^ m[0];
    x[0] = m[0];
    return x;
  endfunction

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] asm_q, asm_d;
  logic [3:0]           ps_q, ps_d;
  logic                 ps_valid_q, ps_valid_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 word_last_q, word_last_d;

  logic                 accept;
  logic                 complete;
  logic [3:0]           m;
  logic [WORD_BITS-1:0] asm_ins;

  assign u_ready_o    = !word_valid_q || word_ready_i;
  assign ps_o         = ps_q;
  assign ps_valid_o   = ps_valid_q;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign word_last_o  = word_last_q;

  always_comb begin
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    ps_d         = ps_q;
    ps_valid_d   = 1'b0;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;

    accept   = u_valid_i && u_ready_o;
    m        = mask_group(u_i, frozen_i);
    complete = accept && ((cnt_q == CNT_W'(GROUPS - 1)) || last_i);

    asm_ins = asm_q;
    asm_ins[{cnt_q, 2'b00} +: 4] = m;

    if (word_valid_q && word_ready_i) begin
      word_valid_d = 1'b0;
    end

    if (accept) begin
      ps_d       = partial_sums(m);
      ps_valid_d = 1'b1;
      if (complete) begin
        // Assembly is cleared on every completion, so unfilled groups read 0.
        word_d       = asm_ins;
        word_valid_d = 1'b1;
        word_last_d  = last_i;
        cnt_d        = '0;
        asm_d        = '0;
      end else begin
        asm_d = asm_ins;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      ps_q         <= '0;
      ps_valid_q   <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      ps_q         <= ps_d;
      ps_valid_q   <= ps_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
    end
  end

endmodule

// File: doc/bit_collector.md
BIT_COLLECTOR -- requirements
Module: bit_collector

Interface
REQ-001 SHALL have parameter WORD_BITS, default 32, output word width; legal values are multiples of 4, minimum 8.
REQ-002 SHALL derive GROUPS = WORD_BITS/4, the number of 4-bit decision groups per word.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port u_valid_i, input, 1, a decision group is presented.
REQ-006 SHALL have port u_i, input, 4, decided bits of one radix-4 group: [3]=u0 (first F), [2]=u1 (first G), [1]=u2 (second F), [0]=u3 (second G).
REQ-007 SHALL have port frozen_i, input, 4, frozen mask aligned with u_i; 1 = frozen.
REQ-008 SHALL have port last_i, input, 1, qualified by u_valid_i; marks the final group of a codeword.
REQ-009 SHALL have port u_ready_o, output, 1, group accepted this cycle when u_valid_i is also high.
REQ-010 SHALL have port ps_o, output, 4, registered partial sums of the last accepted group: [3]=x0, [2]=x1, [1]=x2, [0]=x3.
REQ-011 SHALL have port ps_valid_o, output, 1, one-cycle strobe qualifying ps_o.
REQ-012 SHALL have port word_o, output, WORD_BITS, packed decoded word.
REQ-013 SHALL have port word_valid_o, output, 1, word_o valid.
REQ-014 SHALL have port word_last_o, output, 1, word_o holds the codeword's final group.
REQ-015 SHALL have port word_ready_i, input, 1, downstream accepts word_o.

Function
REQ-016 SHALL accept a group on a rising edge where u_valid_i && u_ready_o.
REQ-017 SHALL drive u_ready_o = !word_valid_o || word_ready_i (combinational), so a completing word always finds the output register free.
REQ-018 SHALL mask each accepted group as m = u_i & ~frozen_i; frozen positions are forced to 0.
REQ-019 SHALL compute partial sums from m: x0=u0^u1^u2^u3, x1=u1^u3, x2=u2^u3, x3=u3.
REQ-020 SHALL register ps_o and pulse ps_valid_o high for exactly the cycle after each accept; ps_o holds its value otherwise.
REQ-021 SHALL keep a group counter cnt, 0..GROUPS-1, and write m into assembly bits [4*cnt+3:4*cnt] on accept.
REQ-022 SHALL complete a word on the accept where cnt==GROUPS-1 or last_i=1.
REQ-023 SHALL, on word completion, load word_o from the assembly bits plus the current m, with unfilled groups =0; set word_valid_o=1, set word_last_o=last_i, clear cnt to 0 and clear the assembly register.
REQ-024 SHALL otherwise increment cnt on each accept.
REQ-025 SHALL assert word_valid_o on the cycle after the completing accept (latency 1).
REQ-026 SHALL hold word_o, word_last_o and word_valid_o stable while word_valid_o && !word_ready_i.
REQ-027 SHALL clear word_valid_o after a handshake (word_valid_o && word_ready_i) unless a new word completes on the same edge, in which case it reloads with no bubble.
REQ-028 SHALL accept back-to-back groups every cycle while word_ready_i=1.
REQ-029 SHALL ignore u_i, frozen_i and last_i when u_valid_i=0.

Reset
REQ-030 SHALL, while rst_i=1, clear cnt and the assembly register and drive word_o=0, word_valid_o=0, word_last_o=0, ps_o=0 and ps_valid_o=0.
REQ-031 SHALL discard any partially assembled word and any pending output word when reset is asserted mid-operation.

Verification (WORD_BITS=8)
REQ-032 Case: groups 0xA then 0x3, frozen=0, word_ready_i=1 -> ps_o=0x2 then 0x5; word_o=0x3A, word_valid_o high 1 cycle after the second accept, word_last_o=0.
REQ-033 Case: u_i=0xF, frozen_i=0xC -> masked group 0x3, ps_o=0x5.
REQ-034 Case: word_valid_o=1 with word_ready_i=0 for 5 cycles -> u_ready_o=0 and word_o stable; after word_ready_i=1, the next group is accepted on that edge.
REQ-035 Case: single group 0x6 with last_i=1 -> word_o=0x06, word_last_o=1, cnt=0.
REQ-036 Case: accept 0x9, pulse rst_i, then accept 0x1 and 0x2 -> word_o=0x21 with no trace of 0x9; all outputs 0 during reset.
REQ-037 Case: continuous stream of 8 groups with word_ready_i=1 -> four words emitted on consecutive-pair boundaries and u_ready_o never low.
